// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver giving the held key code and a key-down level
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       state,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} fsm_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;
    fsm_t          st_q, st_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [7:0]    code_q, code_d;
    logic          state_q, state_d;
    logic          bv_q, bv_d, fe_q, fe_d;

    assign code       = code_q;
    assign state      = state_q;
    assign byte_valid = bv_q;
    assign frame_err  = fe_q;

    // Glitch filter: follow the synchronised clock only after FILTER_LEN differing cycles
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1))
                filt_d = clk_s2_q;
            else
                fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign fall = filt_q & ~filt_d;

    // Frame deframing, timeout supervision and make/break interpretation
    always_comb begin
        st_d    = st_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        code_d  = code_q;
        state_d = state_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        to_d    = (fall || st_q == IDLE) ? '0 : to_q + 1'b1;
        if (st_q != IDLE && to_q == TW'(TIMEOUT_CYCLES)) begin
            fe_d  = 1'b1;
            st_d  = IDLE;
            sh_d  = '0;
            ext_d = 1'b0;
            brk_d = 1'b0;
            to_d  = '0;
        end else if (fall) begin
            case (st_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        st_d  = DATA;
                        bit_d = '0;
                    end
                end
                DATA: begin
                    sh_d  = {dat_s2_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) st_d = PARITY;
                end
                PARITY: begin
                    par_d = dat_s2_q;
                    st_d  = STOP;
                end
                STOP: begin
                    st_d = IDLE;
                    if ((^sh_q ^ par_q) && dat_s2_q) begin
                        bv_d = 1'b1;
                        if (sh_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (sh_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (brk_q) begin
                            state_d = (sh_q == code_q) ? 1'b0 : state_q;
                            brk_d   = 1'b0;
                            ext_d   = 1'b0;
                        end else begin
                            code_d  = sh_q;
                            state_d = 1'b1;
                            ext_d   = 1'b0;
                        end
                    end else begin
                        fe_d  = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    // State registers; lines idle high so synchronisers and filter reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            st_q     <= IDLE;
            bit_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            to_q     <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            code_q   <= 8'h00;
            state_q  <= 1'b0;
            bv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            st_q     <= st_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            to_q     <= to_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            code_q   <= code_d;
            state_q  <= state_d;
            bv_q     <= bv_d;
            fe_q     <= fe_d;
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: scoreboard bench driving PS/2 frames against a key-event model
module tb_ps2_keyboard_rx;
    localparam int FL = 4;
    localparam int TO = 2000;
    localparam int H  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       state;
    logic       byte_valid;
    logic       frame_err;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       st;
    } exp_t;

    exp_t q[$];

    logic [7:0] m_code = 8'h00;
    logic       m_state = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code(code), .state(state), .byte_valid(byte_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Reference model: key-event semantics of one received byte (or a rejected frame)
    task automatic model(input logic [7:0] b, input logic ok);
        exp_t e;
        if (!ok) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            if (b == m_code) m_state = 1'b0;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            m_code  = b;
            m_state = 1'b1;
            m_ext   = 1'b0;
        end
        e.err  = !ok;
        e.code = m_code;
        e.st   = m_state;
        q.push_back(e);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (H) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        model(b, !(bad_par || bad_stop));
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (H) @(posedge clk);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected events still pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] c, input logic s);
        @(negedge clk);
        total++;
        if (code !== c || state !== s || byte_valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL %s: got code=%02h state=%b bv=%b fe=%b, required code=%02h state=%b bv=0 fe=0",
                     name, code, state, byte_valid, frame_err, c, s);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected event
    always @(negedge clk) begin
        if (rst_n && (byte_valid || frame_err)) begin
            exp_t e;
            total++;
            if (byte_valid && frame_err) begin
                bad++;
                $display("FAIL both_pulses: byte_valid and frame_err together, required exclusive");
            end else if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: bv=%b fe=%b code=%02h, required no pulse",
                         byte_valid, frame_err, code);
            end else begin
                e = q.pop_front();
                if (frame_err !== e.err || code !== e.code || state !== e.st) begin
                    bad++;
                    $display("FAIL event: got err=%b code=%02h state=%b, required err=%b code=%02h state=%b",
                             frame_err, code, state, e.err, e.code, e.st);
                end
            end
        end
    end

    logic [7:0] pool [0:8];

    initial begin
        pool[0] = 8'h1C; pool[1] = 8'h1B; pool[2] = 8'h23; pool[3] = 8'h29; pool[4] = 8'h3B;
        pool[5] = 8'h42; pool[6] = 8'hF0; pool[7] = 8'hE0; pool[8] = 8'h00;
        repeat (3) @(posedge clk);
        check_out("reset_values", 8'h00, 1'b0);
        rst_n = 1'b1;
        repeat (10000) @(posedge clk);
        check_out("idle_10000", 8'h00, 1'b0);

        send(8'h1C, 0, 0); drain(200);
        send(8'hF0, 0, 0); send(8'h1C, 0, 0); drain(200);
        check_out("break_1C", 8'h1C, 1'b0);

        send(8'h3B, 0, 0); send(8'h42, 0, 0); send(8'hF0, 0, 0); send(8'h3B, 0, 0); drain(200);
        check_out("stale_break", 8'h42, 1'b1);
        send(8'hF0, 0, 0); send(8'h42, 0, 0); drain(200);
        check_out("break_42", 8'h42, 1'b0);

        send(8'h23, 1, 0); drain(200);
        send(8'h23, 0, 1); drain(200);
        check_out("bad_frames", 8'h42, 1'b0);

        send(8'hE0, 0, 0); send(8'h29, 0, 0); drain(200);
        check_out("ext_make", 8'h29, 1'b1);
        send(8'hF0, 0, 0); send(8'h55, 1, 0); send(8'h29, 0, 0); drain(200);
        check_out("err_clears_brk", 8'h29, 1'b1);

        model(8'h00, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        drain(TO + 300);
        send(8'h1B, 0, 0); drain(200);
        check_out("after_timeout", 8'h1B, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int k;
            k = $urandom_range(0, 8);
            b = (k == 8) ? 8'($urandom_range(1, 8'hDF)) : pool[k];
            send(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
        end
        drain(200);
        check_out("random_end", m_code, m_state);

        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        rst_n = 1'b0;
        ps2_data = 1'b1;
        m_code = 8'h00; m_state = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
        repeat (2) @(posedge clk);
        check_out("mid_frame_reset", 8'h00, 1'b0);
        rst_n = 1'b1;
        repeat (TO + 500) @(posedge clk);
        check_out("post_reset_idle", 8'h00, 1'b0);
        send(8'h1C, 0, 0); drain(200);
        check_out("post_reset_make", 8'h1C, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
